// File: rtl/lc4_mem_pkg.sv
// Shared definitions for the LC4 memory phase sequencer: phase encoding,
// default widths, memory read latency and a strobe-to-phase helper.
package lc4_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned MEM_LAT    = 1;
  localparam int unsigned N_PHASE    = 4;

  // Encoding matches the write-enable generator's phase counter values.
  typedef enum logic [1:0] {
    EXP_I1 = 2'd0,
    EXP_I2 = 2'd1,
    EXP_D  = 2'd2,
    EXP_W  = 2'd3
  } phase_e;

  // Phase strobes as one bus; bit index equals phase number.
  typedef struct packed {
    logic gwe;
    logic dre;
    logic i2re;
    logic i1re;
  } strobe_t;

  // Lowest asserted strobe as a phase; only meaningful when one is set.
  function automatic phase_e strobe_phase(input strobe_t s);
    phase_e p;
    p = EXP_I1;
    if (s.i1re)      p = EXP_I1;
    else if (s.i2re) p = EXP_I2;
    else if (s.dre)  p = EXP_D;
    else if (s.gwe)  p = EXP_W;
    return p;
  endfunction

endpackage

// File: rtl/lc4_phase_checker.sv
// Tracks the expected phase of the i1re/i2re/dre/gwe strobe rotation.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_strb           strobes {gwe, dre, i2re, i1re}
//   o_onehot_c       exactly one strobe asserted this cycle
//   o_legal_c        the single strobe is the expected one
//   o_err_c          this cycle is a sequence violation
//   o_phase_c        phase index of the observed strobe
//   o_close_c        legal gwe closing a clean, seq_ok bundle
//   o_phase_err      sticky violation flag
module lc4_phase_checker
  import lc4_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_strb,
  output logic       o_onehot_c,
  output logic       o_legal_c,
  output logic       o_err_c,
  output logic [1:0] o_phase_c,
  output logic       o_close_c,
  output logic       o_phase_err
);

  phase_e r_state;
  phase_e w_state_nxt;
  logic   r_seq_ok;
  logic   w_seq_ok_nxt;
  logic   r_phase_err;
  logic   w_phase_err_nxt;
  phase_e w_phase;
  logic   w_onehot;
  logic   w_legal;
  logic   w_err;

  // State, seq_ok and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EXP_I1;
      r_seq_ok    <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_seq_ok    <= w_seq_ok_nxt;
      r_phase_err <= w_phase_err_nxt;
    end
  end

  // Next-state and classification of the current strobe pattern.
  always_comb begin
    w_state_nxt     = r_state;
    w_seq_ok_nxt    = r_seq_ok;
    w_phase_err_nxt = r_phase_err;
    w_phase         = strobe_phase(strobe_t'(i_strb));
    w_onehot        = $onehot(i_strb);
    w_legal         = w_onehot && (w_phase == r_state);
    // Any asserted strobe that is not the single expected one is an error.
    w_err           = (|i_strb) && !w_legal;

    if (w_legal) begin
      w_state_nxt = phase_e'(2'(r_state + 2'd1));
    end else if (w_onehot) begin
      // Resync to the phase following the one actually observed.
      w_state_nxt = phase_e'(2'(w_phase + 2'd1));
    end

    if (w_err) begin
      w_seq_ok_nxt    = 1'b0;
      w_phase_err_nxt = 1'b1;
    end else if (w_legal && (r_state == EXP_I1)) begin
      w_seq_ok_nxt = 1'b1;
    end
  end

  assign o_onehot_c  = w_onehot;
  assign o_legal_c   = w_legal;
  assign o_err_c     = w_err;
  assign o_phase_c   = 2'(w_phase);
  assign o_close_c   = w_legal && (r_state == EXP_W) && r_seq_ok;
  assign o_phase_err = r_phase_err;

endmodule

// File: rtl/lc4_mem_phase_seq.sv
// Time-multiplexes one registered-read memory across the four LC4 phases
// (fetch 1, fetch 2, data read, data write) and captures the read data.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i1re, i2re, dre, gwe       one-hot phase strobes
//   i1_addr, i2_addr, d_addr   per-phase addresses
//   d_we, d_wdata              store request and data (gwe phase)
//   mem_addr/we/wdata          combinational memory request
//   mem_rdata                  memory data, one cycle after address
//   i1_data, i2_data, d_rdata  captured read data
//   bundle_valid               pulse after a clean complete bundle
//   phase_err                  sticky sequence error
module lc4_mem_phase_seq
  import lc4_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i1re,
  input  logic              i2re,
  input  logic              dre,
  input  logic              gwe,
  input  logic [ADDR_W-1:0] i1_addr,
  input  logic [ADDR_W-1:0] i2_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] i1_data,
  output logic [DATA_W-1:0] i2_data,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bundle_valid,
  output logic              phase_err
);

  logic [3:0] w_strb;
  logic       w_onehot;
  logic       w_legal;
  logic       w_err;
  logic [1:0] w_phase_raw;
  phase_e     w_phase;
  logic       w_close;
  logic       r_pend_vld;
  phase_e     r_pend_ph;

  assign w_strb  = {gwe, dre, i2re, i1re};
  assign w_phase = phase_e'(w_phase_raw);

  lc4_phase_checker u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_strb      (w_strb),
    .o_onehot_c  (w_onehot),
    .o_legal_c   (w_legal),
    .o_err_c     (w_err),
    .o_phase_c   (w_phase_raw),
    .o_close_c   (w_close),
    .o_phase_err (phase_err)
  );

  // Memory request mux; stores only on a clean single gwe.
  always_comb begin
    mem_addr = '0;
    if (i1re)             mem_addr = i1_addr;
    else if (i2re)        mem_addr = i2_addr;
    else if (dre || gwe)  mem_addr = d_addr;
    mem_we    = gwe & d_we & w_onehot;
    mem_wdata = mem_we ? d_wdata : '0;
  end

  // Remember which legal read is in flight so its data is captured one
  // cycle later, even when idle cycles separate the phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_ph  <= EXP_I1;
    end else begin
      r_pend_vld <= w_legal && (w_phase != EXP_W);
      r_pend_ph  <= w_phase;
    end
  end

  // Capture registers and bundle-valid pulse; an erroring cycle skips capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_data      <= '0;
      i2_data      <= '0;
      d_rdata      <= '0;
      bundle_valid <= 1'b0;
    end else begin
      bundle_valid <= w_close;
      if (r_pend_vld && !w_err) begin
        case (r_pend_ph)
          EXP_I1:  i1_data <= mem_rdata;
          EXP_I2:  i2_data <= mem_rdata;
          EXP_D:   d_rdata <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lc4_mem_phase_seq.sv
// Randomized and directed bench for lc4_mem_phase_seq with a
// transaction-level reference model of phases, captures and memory.
module tb_lc4_mem_phase_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i1re, i2re, dre, gwe;
  logic [15:0] i1_addr, i2_addr, d_addr;
  logic        d_we;
  logic [15:0] d_wdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] i1_data, i2_data, d_rdata;
  logic        bundle_valid, phase_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory attached to the DUT: registered read, read-before-write.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always #5 clk = ~clk;

  lc4_mem_phase_seq dut (
    .clk(clk), .rst_n(rst_n),
    .i1re(i1re), .i2re(i2re), .dre(dre), .gwe(gwe),
    .i1_addr(i1_addr), .i2_addr(i2_addr), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .i1_data(i1_data), .i2_data(i2_data), .d_rdata(d_rdata),
    .bundle_valid(bundle_valid), .phase_err(phase_err)
  );

  // Reference model state.
  logic [15:0] ref_mem [0:65535];
  int          m_exp;       // phase number expected next (0..3)
  bit          m_seq_ok;
  bit          m_err;
  bit          m_bv;
  logic [15:0] m_i1, m_i2, m_d;
  bit          m_pend;      // a legal read issued last cycle awaits capture
  int          m_pend_ph;
  logic [15:0] m_pend_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exp = 0; m_seq_ok = 0; m_err = 0; m_bv = 0;
    m_i1 = 0; m_i2 = 0; m_d = 0; m_pend = 0; m_pend_ph = 0; m_pend_val = 0;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".i1_data"}, 32'(i1_data), 32'(m_i1));
    check_eq({tag, ".i2_data"}, 32'(i2_data), 32'(m_i2));
    check_eq({tag, ".d_rdata"}, 32'(d_rdata), 32'(m_d));
    check_eq({tag, ".bundle_valid"}, 32'(bundle_valid), 32'(m_bv));
    check_eq({tag, ".phase_err"}, 32'(phase_err), 32'(m_err));
  endtask

  // One clock cycle with strobe pattern s (bit k = phase k); entered and
  // left 1 time unit after a rising edge.
  task automatic cyc(input logic [3:0] s, input string tag);
    int          n;
    bit          legal, err, exp_we;
    logic [15:0] exp_addr;
    int          obs;
    {gwe, dre, i2re, i1re} = s;
    #2;
    n   = $countones(s);
    obs = s[0] ? 0 : s[1] ? 1 : s[2] ? 2 : 3;
    exp_addr = (n == 0) ? 16'h0 : (obs == 0) ? i1_addr : (obs == 1) ? i2_addr : d_addr;
    exp_we   = (s == 4'b1000) && d_we;
    if (n <= 1) check_eq({tag, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    check_eq({tag, ".mem_we"}, 32'(mem_we), 32'(exp_we));
    check_eq({tag, ".mem_wdata"}, 32'(mem_wdata), exp_we ? 32'(d_wdata) : 32'h0);

    legal = (n == 1) && (obs == m_exp);
    err   = (n >= 1) && !legal;
    if (m_pend && !err) begin
      if (m_pend_ph == 0) m_i1 = m_pend_val;
      else if (m_pend_ph == 1) m_i2 = m_pend_val;
      else m_d = m_pend_val;
    end
    m_pend     = legal && (m_exp != 3);
    m_pend_ph  = m_exp;
    m_pend_val = ref_mem[exp_addr];
    m_bv       = legal && (m_exp == 3) && m_seq_ok;
    if (err) begin m_seq_ok = 0; m_err = 1; end
    else if (legal && m_exp == 0) m_seq_ok = 1;
    if (exp_we) ref_mem[d_addr] = d_wdata;
    if (legal) m_exp = (m_exp + 1) % 4;
    else if (n == 1) m_exp = (obs + 1) % 4;

    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic bundle(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] ad,
                        input logic we, input logic [15:0] wd, input int gap, input string tag);
    i1_addr = a1; i2_addr = a2; d_addr = ad; d_we = we; d_wdata = wd;
    cyc(4'b0001, tag); for (int g = 0; g < gap; g++) cyc(4'b0000, tag);
    cyc(4'b0010, tag); for (int g = 0; g < gap; g++) cyc(4'b0000, tag);
    cyc(4'b0100, tag); for (int g = 0; g < gap; g++) cyc(4'b0000, tag);
    cyc(4'b1000, tag);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'h0010;
      1:       return 16'h0011;
      2:       return 16'h4000;
      default: return 16'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    logic [3:0] s;
    int         r;
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = 16'(a) ^ 16'h5555;
      ref_mem[a] = 16'(a) ^ 16'h5555;
    end
    mem[16'h0010] = 16'h1234; ref_mem[16'h0010] = 16'h1234;
    mem[16'h0011] = 16'hABCD; ref_mem[16'h0011] = 16'hABCD;
    mem[16'h4000] = 16'h00FF; ref_mem[16'h4000] = 16'h00FF;

    rst_n = 1'b0; {gwe, dre, i2re, i1re} = 4'b0;
    i1_addr = 0; i2_addr = 0; d_addr = 0; d_we = 0; d_wdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean bundle, then one idle cycle so the valid pulse is seen to drop.
    bundle(16'h0010, 16'h0011, 16'h4000, 1'b0, 16'h0, 0, "clean");
    check_eq("clean.i1_abs", 32'(i1_data), 32'h1234);
    check_eq("clean.i2_abs", 32'(i2_data), 32'hABCD);
    check_eq("clean.d_abs", 32'(d_rdata), 32'h00FF);
    check_eq("clean.bv_abs", 32'(bundle_valid), 32'h1);
    cyc(4'b0000, "clean_idle");
    check_eq("clean.bv_drop", 32'(bundle_valid), 32'h0);

    // Store returns old data; next bundle sees the new value.
    bundle(16'h0010, 16'h0011, 16'h4000, 1'b1, 16'h5A5A, 0, "store");
    check_eq("store.d_old", 32'(d_rdata), 32'h00FF);
    bundle(16'h0010, 16'h0011, 16'h4000, 1'b0, 16'h0, 0, "store2");
    check_eq("store.d_new", 32'(d_rdata), 32'h5A5A);

    // Idle gaps between phases.
    bundle(16'h0011, 16'h0010, 16'h0003, 1'b0, 16'h0, 2, "gaps");
    check_eq("gaps.i1_abs", 32'(i1_data), 32'hABCD);
    check_eq("gaps.err_abs", 32'(phase_err), 32'h0);

    // Reset asserted in the middle of the dre cycle.
    i1_addr = 16'h0005; i2_addr = 16'h0006; d_addr = 16'h0007; d_we = 1'b0;
    cyc(4'b0001, "rstmid"); cyc(4'b0010, "rstmid");
    {gwe, dre, i2re, i1re} = 4'b0100;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("rstmid.async");
    {gwe, dre, i2re, i1re} = 4'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bundle(16'h0010, 16'h0011, 16'h4000, 1'b0, 16'h0, 0, "post_rst");
    check_eq("post_rst.bv_abs", 32'(bundle_valid), 32'h1);

    // Out-of-order: i1re then dre; resync to EXP_W, no valid until clean bundle.
    i1_addr = 16'h0001; d_addr = 16'h0002;
    cyc(4'b0001, "ooo"); cyc(4'b0100, "ooo");
    check_eq("ooo.err_abs", 32'(phase_err), 32'h1);
    cyc(4'b1000, "ooo_w");
    check_eq("ooo.no_bv", 32'(bundle_valid), 32'h0);
    bundle(16'h0010, 16'h0011, 16'h4000, 1'b0, 16'h0, 0, "ooo_clean");
    check_eq("ooo.bv_abs", 32'(bundle_valid), 32'h1);

    // Multiple strobes with a store request: no write.
    d_addr = 16'h4000; d_we = 1'b1; d_wdata = 16'hDEAD;
    cyc(4'b1001, "multi");
    d_we = 1'b0;
    bundle(16'h0010, 16'h0011, 16'h4000, 1'b0, 16'h0, 0, "multi_rd");
    check_eq("multi.mem_kept", 32'(d_rdata), 32'h5A5A);

    // Randomized traffic, mostly in-order with idles, misorders and collisions.
    for (int k = 0; k < 600; k++) begin
      i1_addr = rand_addr(); i2_addr = rand_addr(); d_addr = rand_addr();
      d_we = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom());
      r = $urandom_range(0, 99);
      if (r < 72)      s = 4'(1 << m_exp);
      else if (r < 84) s = 4'b0000;
      else if (r < 93) s = 4'(1 << $urandom_range(0, 3));
      else begin
        s = 4'($urandom_range(1, 15));
        if ($countones(s) < 2) s = 4'b0011;
      end
      cyc(s, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
